// File: rtl/sum_bcd_converter_pkg.sv
// Shared definitions for the sum_bcd_converter block.
//   state_e          FSM state encoding (IDLE/SHIFT/DONE)
//   BCD_DIGIT_W      width of one BCD digit
//   ADD3_THRESHOLD   digit value at or above which double-dabble adds 3
//   SEG_BLANK        active-low seven-segment pattern with every segment off
//   seg7_decode()    BCD digit to active-low g..a segment pattern (DE1-SoC HEX)
package sum_bcd_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [6:0] SEG_BLANK      = 7'h7F;

  // Segment order is {g,f,e,d,c,b,a}; a segment lights when its bit is 0.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sum_bcd_converter_if.sv
// Start/done handshake and result bus between the adder side and the
// binary-to-BCD converter.
//   start, bin_in         request a conversion of bin_in (driven by master)
//   busy, done            conversion status (driven by slave)
//   bcd_hund/tens/ones    last completed result (driven by slave)
//   hex0..hex2            active-low segment patterns, only when
//                         SUM_BCD_SEG_DECODE_EN is defined
// Modports: master = requester, slave = converter.
interface sum_bcd_converter_if #(
  parameter int WIDTH = 9
);
  import sum_bcd_converter_pkg::*;

  logic                   start;
  logic [WIDTH-1:0]       bin_in;
  logic                   busy;
  logic                   done;
  logic [BCD_DIGIT_W-1:0] bcd_ones;
  logic [BCD_DIGIT_W-1:0] bcd_tens;
  logic [BCD_DIGIT_W-1:0] bcd_hund;
`ifdef SUM_BCD_SEG_DECODE_EN
  logic [6:0]             hex0;
  logic [6:0]             hex1;
  logic [6:0]             hex2;
`endif

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_ones,
    input  bcd_tens,
    input  bcd_hund
`ifdef SUM_BCD_SEG_DECODE_EN
    ,
    input  hex0,
    input  hex1,
    input  hex2
`endif
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_ones,
    output bcd_tens,
    output bcd_hund
`ifdef SUM_BCD_SEG_DECODE_EN
    ,
    output hex0,
    output hex1,
    output hex2
`endif
  );

endinterface

// File: rtl/sum_bcd_converter_bcd_digit_adj.sv
// Double-dabble digit correction: one BCD digit in, the same digit plus 3
// out when it is 5 or more, so that the following left shift carries
// correctly into the next decimal digit.
//   digit_in   current scratch digit
//   digit_out  corrected digit, ready to be shifted
module bcd_digit_adj
  import sum_bcd_converter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Add-3 correction; a digit of at most 9 plus 3 still fits in 4 bits.
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= ADD3_THRESHOLD) begin
      digit_out = digit_in + 4'd3;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the 9-bit
// ripple-adder result {c_out, s[7:0]}, driving three BCD digits for the
// DE1-SoC HEX displays.
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   sum_bcd_converter_if.slave: start/bin_in in; busy/done/bcd_* out
// Optional: define SUM_BCD_SEG_DECODE_EN to add hex0..hex2 segment outputs
// (combinational decode of the registered digits, leading-zero blanked).
//
// Timing: start sampled at edge N; WIDTH shifts on edges N+1..N+WIDTH; the
// FSM sits in DONE for one cycle and the digits are registered at edge
// N+WIDTH+1, together with the one-cycle done pulse. busy is the registered
// image of the SHIFT state, so it is high for exactly WIDTH cycles.
module sum_bcd_converter
  import sum_bcd_converter_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  sum_bcd_converter_if.slave   bus
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int OUT_W = BCD_DIGIT_W * 3;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   bcd_q, bcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SCR_W-1:0]   adj_s;

  // All digits are corrected in parallel before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Next-state and datapath logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    // Status outputs are one cycle behind the state they describe.
    busy_d    = (state_q == ST_SHIFT);
    done_d    = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shift_d   = bus.bin_in;
          scratch_d = {SCR_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        // start is deliberately ignored here; bin_in was captured already.
        {scratch_d, shift_d} = {adj_s, shift_q} << 1'b1;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_DONE: begin
        // scratch holds the finished digits; publish them only here so the
        // outputs never show intermediate values.
        bcd_d = scratch_q[OUT_W-1:0];
        if (bus.start) begin
          shift_d   = bus.bin_in;
          scratch_d = {SCR_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= {WIDTH{1'b0}};
      scratch_q <= {SCR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      bcd_q     <= {OUT_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_ones = bcd_q[3:0];
  assign bus.bcd_tens = bcd_q[7:4];
  assign bus.bcd_hund = bcd_q[11:8];

`ifdef SUM_BCD_SEG_DECODE_EN
  logic [6:0] hex0_s;
  logic [6:0] hex1_s;
  logic [6:0] hex2_s;

  // Segment decode with leading-zero blanking; the ones digit always shows.
  always_comb begin
    hex0_s = seg7_decode(bcd_q[3:0]);
    if (bcd_q[11:8] == 4'd0) begin
      hex2_s = SEG_BLANK;
    end else begin
      hex2_s = seg7_decode(bcd_q[11:8]);
    end
    if ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) begin
      hex1_s = SEG_BLANK;
    end else begin
      hex1_s = seg7_decode(bcd_q[7:4]);
    end
  end

  assign bus.hex0 = hex0_s;
  assign bus.hex1 = hex1_s;
  assign bus.hex2 = hex2_s;
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Self-checking bench for sum_bcd_converter: table-driven vectors, a full
// sweep, random adder-style operands, and hand-written handshake sequences.
module tb_sum_bcd_converter;

  typedef struct {
    logic [8:0] bin;
    int         h;
    int         t;
    int         o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   prev_h = 0;
  int   prev_t = 0;
  int   prev_o = 0;

  always #5 clk = ~clk;

  sum_bcd_converter_if #(.WIDTH(9)) bus_if ();

  sum_bcd_converter #(.WIDTH(9), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef SUM_BCD_SEG_DECODE_EN
  function automatic int seg_of(input int d);
    int tbl [10] = '{64, 121, 36, 48, 25, 18, 2, 120, 0, 16};
    return tbl[d];
  endfunction
`endif

  task automatic chk_out(input string tag, input int eh, input int et, input int eo);
    chk({tag, "_hund"}, int'(bus_if.bcd_hund), eh);
    chk({tag, "_tens"}, int'(bus_if.bcd_tens), et);
    chk({tag, "_ones"}, int'(bus_if.bcd_ones), eo);
`ifdef SUM_BCD_SEG_DECODE_EN
    chk({tag, "_hex2"}, int'(bus_if.hex2), (eh == 0) ? 127 : seg_of(eh));
    chk({tag, "_hex1"}, int'(bus_if.hex1), (eh == 0 && et == 0) ? 127 : seg_of(et));
    chk({tag, "_hex0"}, int'(bus_if.hex0), seg_of(eo));
`endif
  endtask

  // One complete conversion with latency, busy width, hold and pulse checks.
  task automatic run_conv(input logic [8:0] v, input int eh, input int et,
                          input int eo, input string tag);
    int k;
    int bcnt;
    bit seen;
    bit hold_ok;
    bus_if.start  = 1'b1;
    bus_if.bin_in = v;
    tick();
    bus_if.start = 1'b0;
    k = 0; bcnt = 0; seen = 1'b0; hold_ok = 1'b1;
    while (!seen && k < 30) begin
      bus_if.bin_in = 9'($urandom);
      tick();
      k++;
      if (bus_if.done) begin
        seen = 1'b1;
      end else begin
        if (bus_if.busy) bcnt++;
        if (int'(bus_if.bcd_hund) != prev_h || int'(bus_if.bcd_tens) != prev_t ||
            int'(bus_if.bcd_ones) != prev_o) hold_ok = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, k, 10);
    chk({tag, "_busy_cycles"}, bcnt, 9);
    chk({tag, "_busy_at_done"}, int'(bus_if.busy), 0);
    chk({tag, "_hold"}, int'(hold_ok), 1);
    chk_out(tag, eh, et, eo);
    prev_h = eh; prev_t = et; prev_o = eo;
    tick();
    chk({tag, "_done_pulse"}, int'(bus_if.done), 0);
  endtask

  initial begin
    vec_t       tbl [7];
    logic [8:0] v;
    int         a, b, c, k, nd, fk;
    int         gh, gt, go;

    tbl[0] = '{9'd0,   0, 0, 0};
    tbl[1] = '{9'd511, 5, 1, 1};
    tbl[2] = '{9'd123, 1, 2, 3};
    tbl[3] = '{9'd99,  0, 9, 9};
    tbl[4] = '{9'd300, 3, 0, 0};
    tbl[5] = '{9'd255, 2, 5, 5};
    tbl[6] = '{9'd410, 4, 1, 0};

    rst = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.bin_in = 9'd0;
    tick();
    tick();
    chk("reset_busy", int'(bus_if.busy), 0);
    chk("reset_done", int'(bus_if.done), 0);
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_conv(tbl[i].bin, tbl[i].h, tbl[i].t, tbl[i].o, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 512; i++) begin
      run_conv(9'(i), i / 100, (i / 10) % 10, i % 10, $sformatf("sweep%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 1));
      v = 9'(a + b + c);
      run_conv(v, (a + b + c) / 100, ((a + b + c) / 10) % 10, (a + b + c) % 10,
               $sformatf("rand%0d", i));
    end

    // A second start during a conversion must be ignored.
    bus_if.start  = 1'b1;
    bus_if.bin_in = 9'd123;
    tick();
    nd = 0; fk = -1; gh = 0; gt = 0; go = 0;
    for (int i = 1; i <= 30; i++) begin
      bus_if.start  = (i == 3);
      bus_if.bin_in = (i == 3) ? 9'd45 : 9'($urandom);
      tick();
      if (bus_if.done) begin
        nd++;
        if (fk < 0) begin
          fk = i;
          gh = int'(bus_if.bcd_hund); gt = int'(bus_if.bcd_tens); go = int'(bus_if.bcd_ones);
        end
      end
    end
    chk("midstart_done_count", nd, 1);
    chk("midstart_latency", fk, 10);
    chk("midstart_hund", gh, 1);
    chk("midstart_tens", gt, 2);
    chk("midstart_ones", go, 3);
    prev_h = 1; prev_t = 2; prev_o = 3;

    // start held through the DONE cycle chains straight into the next value.
    bus_if.start  = 1'b1;
    bus_if.bin_in = 9'd123;
    tick();
    bus_if.bin_in = 9'd99;
    k = 0;
    while (!bus_if.done && k < 30) begin tick(); k++; end
    chk("b2b_first_latency", k, 10);
    chk_out("b2b_first", 1, 2, 3);
    bus_if.start = 1'b0;
    k = 0;
    tick(); k++;
    while (!bus_if.done && k < 30) begin tick(); k++; end
    chk("b2b_second_latency", k, 10);
    chk_out("b2b_second", 0, 9, 9);
    tick();
    chk("b2b_done_pulse", int'(bus_if.done), 0);

    // Asynchronous reset in the middle of a conversion.
    bus_if.start  = 1'b1;
    bus_if.bin_in = 9'd300;
    tick();
    bus_if.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("rstmid_busy_before", int'(bus_if.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_busy", int'(bus_if.busy), 0);
    chk("rstmid_done", int'(bus_if.done), 0);
    chk_out("rstmid", 0, 0, 0);
    tick();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus_if.done) nd++;
    end
    chk("rstmid_no_done", nd, 0);
    prev_h = 0; prev_t = 0; prev_o = 0;
    run_conv(9'd300, 3, 0, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
